// File: rtl/sw_operand_reader.sv
// Board operand reader: debounces KEY_N, latches SW into A then B, and offers {A,B} downstream via valid/ready.
// Optional build macro DIGIT_RANGE_CHECK_EN rejects entries above 9 and pulses entry_err.
module sw_operand_reader #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             CLOCK_50,
    input  logic             RESET_N,
    input  logic [WIDTH-1:0] SW,
    input  logic             KEY_N,
    input  logic             operands_ready,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    output logic             operands_valid,
    output logic [1:0]       LEDG,
    output logic             entry_err
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) + 1 : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    // State codes double as the LEDG pattern.
    localparam logic [1:0] WAIT_A = 2'b01;
    localparam logic [1:0] WAIT_B = 2'b10;
    localparam logic [1:0] HOLD   = 2'b11;

    logic             r_sync1;
    logic             r_sync2;
    logic [CNT_W-1:0] r_cnt;
    logic             r_deb;
    logic             r_deb_d;
    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_valid;
    logic             w_press;
    logic             w_reject;

    // Two-flop synchronizer; idle level is released (high).
    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= KEY_N;
            r_sync2 <= r_sync1;
        end
    end

    // Level changes only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            r_cnt <= '0;
            r_deb <= 1'b1;
        end else if (r_sync2 == r_deb) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_MAX) begin
            r_deb <= r_sync2;
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            r_deb_d <= 1'b1;
        end else begin
            r_deb_d <= r_deb;
        end
    end

    assign w_press = r_deb_d & ~r_deb;

`ifdef DIGIT_RANGE_CHECK_EN
    assign w_reject = (32'(SW) > 32'd9);
`else
    assign w_reject = 1'b0;
`endif

`ifdef DIGIT_RANGE_CHECK_EN
    logic r_err;

    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_press && w_reject && (r_state != HOLD);
        end
    end

    assign entry_err = r_err;
`else
    assign entry_err = 1'b0;
`endif

    // Entry FSM; presses arriving in HOLD are dropped, even on the handshake cycle.
    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            r_state <= WAIT_A;
            r_a     <= '0;
            r_b     <= '0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                WAIT_A: begin
                    if (w_press && !w_reject) begin
                        r_a     <= SW;
                        r_state <= WAIT_B;
                    end
                end
                WAIT_B: begin
                    if (w_press && !w_reject) begin
                        r_b     <= SW;
                        r_valid <= 1'b1;
                        r_state <= HOLD;
                    end
                end
                HOLD: begin
                    if (r_valid && operands_ready) begin
                        r_valid <= 1'b0;
                        r_state <= WAIT_A;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_state <= WAIT_A;
                end
            endcase
        end
    end

    assign a_out          = r_a;
    assign b_out          = r_b;
    assign operands_valid = r_valid;
    assign LEDG           = r_state;

endmodule

// File: tb/tb_sw_operand_reader.sv
// Directed bench for sw_operand_reader with DEBOUNCE_CYCLES=4, WIDTH=4.
module tb_sw_operand_reader;

    logic       CLOCK_50 = 1'b0;
    logic       RESET_N  = 1'b0;
    logic [3:0] SW       = 4'd0;
    logic       KEY_N    = 1'b1;
    logic       operands_ready = 1'b0;
    logic [3:0] a_out;
    logic [3:0] b_out;
    logic       operands_valid;
    logic [1:0] LEDG;
    logic       entry_err;

    int n_vec = 0;
    int n_err = 0;

    sw_operand_reader #(.WIDTH(4), .DEBOUNCE_CYCLES(4)) dut (
        .CLOCK_50       (CLOCK_50),
        .RESET_N        (RESET_N),
        .SW             (SW),
        .KEY_N          (KEY_N),
        .operands_ready (operands_ready),
        .a_out          (a_out),
        .b_out          (b_out),
        .operands_valid (operands_valid),
        .LEDG           (LEDG),
        .entry_err      (entry_err)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Clean press: 10 cycles low, 10 cycles high.
    task automatic press(input logic [3:0] sw);
        SW    = sw;
        KEY_N = 1'b0;
        repeat (10) tick();
        KEY_N = 1'b1;
        repeat (10) tick();
    endtask

    initial begin
        // Reset and idle
        repeat (2) tick();
        RESET_N = 1'b1;
        chk("reset_a", a_out, 0);
        chk("reset_b", b_out, 0);
        chk("reset_valid", operands_valid, 0);
        chk("reset_ledg", LEDG, 2'b01);
        chk("reset_err", entry_err, 0);
        for (int i = 0; i < 50; i++) begin
            tick();
            chk("idle", {a_out, b_out, operands_valid, LEDG}, {4'd0, 4'd0, 1'b0, 2'b01});
        end

        // A=3, latched on the 7th edge after KEY_N falls
        SW    = 4'd3;
        KEY_N = 1'b0;
        repeat (6) tick();
        chk("a_edge6_ledg", LEDG, 2'b01);
        tick();
        chk("a_edge7_ledg", LEDG, 2'b10);
        chk("a_edge7_a", a_out, 3);
        repeat (3) tick();
        KEY_N = 1'b1;
        repeat (10) tick();
        chk("a_release_ledg", LEDG, 2'b10);

        // B=5 with ready already high: valid lasts one cycle
        operands_ready = 1'b1;
        SW    = 4'd5;
        KEY_N = 1'b0;
        repeat (6) tick();
        chk("b_edge6_valid", operands_valid, 0);
        chk("b_edge6_ledg", LEDG, 2'b10);
        tick();
        chk("b_edge7_ledg", LEDG, 2'b11);
        chk("b_edge7_b", b_out, 5);
        chk("b_edge7_valid", operands_valid, 1);
        tick();
        chk("hs_valid", operands_valid, 0);
        chk("hs_ledg", LEDG, 2'b01);
        chk("hs_keep_ab", {a_out, b_out}, {4'd3, 4'd5});
        tick();
        KEY_N = 1'b1;
        repeat (10) tick();
        operands_ready = 1'b0;

        // Bounce: five 3-cycle glitches then a clean 10-cycle low
        SW = 4'd2;
        for (int g = 0; g < 5; g++) begin
            KEY_N = 1'b0;
            repeat (3) tick();
            KEY_N = 1'b1;
            repeat (3) tick();
        end
        chk("bounce_ledg", LEDG, 2'b01);
        chk("bounce_a", a_out, 3);
        KEY_N = 1'b0;
        repeat (6) tick();
        chk("bounce_edge6_ledg", LEDG, 2'b01);
        tick();
        chk("bounce_edge7_ledg", LEDG, 2'b10);
        chk("bounce_edge7_a", a_out, 2);
        repeat (3) tick();
        KEY_N = 1'b1;
        repeat (10) tick();
        chk("bounce_single_event", LEDG, 2'b10);

        // HOLD with ready low; extra press is discarded
        press(4'd5);
        chk("hold_ledg", LEDG, 2'b11);
        chk("hold_valid", operands_valid, 1);
        repeat (20) tick();
        chk("hold20_valid", operands_valid, 1);
        press(4'd9);
        chk("hold_press_ledg", LEDG, 2'b11);
        chk("hold_press_ab", {a_out, b_out}, {4'd2, 4'd5});
        chk("hold_press_valid", operands_valid, 1);
        operands_ready = 1'b1;
        tick();
        chk("hold_hs_valid", operands_valid, 0);
        chk("hold_hs_ledg", LEDG, 2'b01);
        operands_ready = 1'b0;

        // Reset in WAIT_B discards the partial entry
        press(4'd7);
        chk("mid_a", a_out, 7);
        chk("mid_ledg", LEDG, 2'b10);
        RESET_N = 1'b0;
        tick();
        RESET_N = 1'b1;
        chk("mid_rst_a", a_out, 0);
        chk("mid_rst_ledg", LEDG, 2'b01);
        chk("mid_rst_valid", operands_valid, 0);
        press(4'd6);
        chk("fresh_a", a_out, 6);
        chk("fresh_ledg", LEDG, 2'b10);
        chk("fresh_b", b_out, 0);
        press(4'd1);
        operands_ready = 1'b1;
        tick();
        operands_ready = 1'b0;
        chk("pair2_ledg", LEDG, 2'b01);
        chk("pair2_ab", {a_out, b_out}, {4'd6, 4'd1});

        // SW=12 in WAIT_A: range boundary
        SW    = 4'd12;
        KEY_N = 1'b0;
        repeat (6) tick();
        chk("rng_edge6_err", entry_err, 0);
        tick();
`ifdef DIGIT_RANGE_CHECK_EN
        chk("rng_err_pulse", entry_err, 1);
        chk("rng_ledg", LEDG, 2'b01);
        chk("rng_a", a_out, 6);
        tick();
        chk("rng_err_end", entry_err, 0);
`else
        chk("rng_err_tied", entry_err, 0);
        chk("rng_ledg", LEDG, 2'b10);
        chk("rng_a", a_out, 12);
        tick();
        chk("rng_err_next", entry_err, 0);
`endif
        KEY_N = 1'b1;
        repeat (10) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
